// File: rtl/rangefinder_sopc_sys_id_checker_pkg.sv
// Shared definitions for the system-ID checker: FSM state encoding and slave word addresses.
package rangefinder_sopc_sys_id_checker_pkg;

  typedef enum logic [1:0] {
    ST_WAIT  = 2'd0,
    ST_RD_ID = 2'd1,
    ST_RD_TS = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  localparam logic ADDR_ID = 1'b0;
  localparam logic ADDR_TS = 1'b1;

endpackage

// File: rtl/rangefinder_sopc_avm_read_timer.sv
// Per-read stall counter; expired is combinational and fires on the TIMEOUT_CYCLES-th stalled cycle.
// Latency: expired same cycle as the final stall; clear has priority over counting.
module rangefinder_sopc_avm_read_timer #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic clock,
  input  logic reset_n,
  input  logic clear,
  input  logic stall,
  output logic expired
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (stall) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign expired = stall && (cnt == LAST);

endmodule

// File: rtl/rangefinder_sopc_sys_id_checker.sv
// Avalon-MM read master that fetches sys-id word 0 (ID) and word 1 (timestamp) and checks them.
// Read strobe/address are registered and held stable while the slave asserts waitrequest.
module rangefinder_sopc_sys_id_checker
  import rangefinder_sopc_sys_id_checker_pkg::*;
#(
  parameter logic [31:0] EXPECTED_ID    = 32'h0000_0000,
  parameter logic [31:0] EXPECTED_TS    = 32'h0000_0000,
  parameter int          START_DELAY    = 16,
  parameter int          TIMEOUT_CYCLES = 255
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        recheck,
  output logic        avm_address,
  output logic        avm_read,
  input  logic        avm_waitrequest,
  input  logic [31:0] avm_readdata,
  output logic [31:0] id_value,
  output logic [31:0] ts_value,
  output logic        busy,
  output logic        done,
  output logic        id_ok,
  output logic        id_mismatch,
  output logic        ts_mismatch,
  output logic        timeout
);

  localparam int DW = (START_DELAY > 1) ? $clog2(START_DELAY) : 1;
  localparam logic [DW-1:0] DELAY_INIT = DW'(START_DELAY - 1);

  state_e        state_q, state_d;
  logic [DW-1:0] dly_q, dly_d;
  logic          read_d, addr_d, busy_d, done_d, ok_d;
  logic          idm_d, tsm_d, to_d;
  logic [31:0]   id_d, ts_d;
  logic          timer_clear, expired, xfer;

  assign xfer = avm_read && !avm_waitrequest;

  rangefinder_sopc_avm_read_timer #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_read_timer (
    .clock   (clock),
    .reset_n (reset_n),
    .clear   (timer_clear),
    .stall   (avm_read && avm_waitrequest),
    .expired (expired)
  );

  always_comb begin
    state_d     = state_q;
    dly_d       = dly_q;
    read_d      = avm_read;
    addr_d      = avm_address;
    id_d        = id_value;
    ts_d        = ts_value;
    idm_d       = id_mismatch;
    tsm_d       = ts_mismatch;
    to_d        = timeout;
    done_d      = done;
    ok_d        = id_ok;
    timer_clear = 1'b0;

    unique case (state_q)
      ST_WAIT: begin
        if (dly_q == '0) begin
          state_d     = ST_RD_ID;
          read_d      = 1'b1;
          addr_d      = ADDR_ID;
          timer_clear = 1'b1;
        end else begin
          dly_d = dly_q - 1'b1;
        end
      end
      ST_RD_ID: begin
        if (xfer) begin
          id_d        = avm_readdata;
          idm_d       = (avm_readdata != EXPECTED_ID);
          state_d     = ST_RD_TS;
          addr_d      = ADDR_TS;
          timer_clear = 1'b1;
        end else if (expired) begin
          read_d  = 1'b0;
          to_d    = 1'b1;
          done_d  = 1'b1;
          ok_d    = 1'b0;
          state_d = ST_DONE;
        end
      end
      ST_RD_TS: begin
        if (xfer) begin
          ts_d    = avm_readdata;
          tsm_d   = (avm_readdata != EXPECTED_TS);
          read_d  = 1'b0;
          addr_d  = ADDR_ID;
          done_d  = 1'b1;
          // id_mismatch is already settled; timestamp verdict folds in from the live bus.
          ok_d    = !id_mismatch && (avm_readdata == EXPECTED_TS);
          state_d = ST_DONE;
        end else if (expired) begin
          read_d  = 1'b0;
          addr_d  = ADDR_ID;
          to_d    = 1'b1;
          done_d  = 1'b1;
          ok_d    = 1'b0;
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        if (recheck) begin
          // Captured words survive until overwritten by the new reads.
          idm_d       = 1'b0;
          tsm_d       = 1'b0;
          to_d        = 1'b0;
          done_d      = 1'b0;
          ok_d        = 1'b0;
          read_d      = 1'b1;
          addr_d      = ADDR_ID;
          timer_clear = 1'b1;
          state_d     = ST_RD_ID;
        end
      end
      default: begin
        state_d = ST_WAIT;
        dly_d   = DELAY_INIT;
        read_d  = 1'b0;
      end
    endcase
  end

  assign busy_d = (state_d != ST_DONE);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_WAIT;
      dly_q       <= DELAY_INIT;
      avm_read    <= 1'b0;
      avm_address <= ADDR_ID;
      id_value    <= '0;
      ts_value    <= '0;
      id_mismatch <= 1'b0;
      ts_mismatch <= 1'b0;
      timeout     <= 1'b0;
      done        <= 1'b0;
      id_ok       <= 1'b0;
      busy        <= 1'b0;
    end else begin
      state_q     <= state_d;
      dly_q       <= dly_d;
      avm_read    <= read_d;
      avm_address <= addr_d;
      id_value    <= id_d;
      ts_value    <= ts_d;
      id_mismatch <= idm_d;
      ts_mismatch <= tsm_d;
      timeout     <= to_d;
      done        <= done_d;
      id_ok       <= ok_d;
      busy        <= busy_d;
    end
  end

endmodule

// File: tb/tb_rangefinder_sopc_sys_id_checker.sv
// Directed bench for the sys-id checker with a small Avalon slave model (programmable stall length).
module tb_rangefinder_sopc_sys_id_checker;

  localparam logic [31:0] EXP_ID = 32'h1234_5678;
  localparam logic [31:0] EXP_TS = 32'h6543_2100;
  localparam int          SD     = 4;
  localparam int          TO     = 8;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        recheck = 1'b0;
  logic        avm_address, avm_read, avm_waitrequest;
  logic [31:0] avm_readdata;
  logic [31:0] id_value, ts_value;
  logic        busy, done, id_ok, id_mismatch, ts_mismatch, timeout;

  logic [31:0] id_resp = EXP_ID;
  logic [31:0] ts_resp = EXP_TS;
  int          stall_len = 0;
  int          stall_ctr;
  int          hold_viol = 0;
  int          ts_issued = 0;
  logic        prev_hold = 1'b0;
  logic        prev_addr = 1'b0;

  int pass_cnt = 0;
  int total_cnt = 0;

  always #5 clock = ~clock;

  rangefinder_sopc_sys_id_checker #(
    .EXPECTED_ID    (EXP_ID),
    .EXPECTED_TS    (EXP_TS),
    .START_DELAY    (SD),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clock           (clock),
    .reset_n         (reset_n),
    .recheck         (recheck),
    .avm_address     (avm_address),
    .avm_read        (avm_read),
    .avm_waitrequest (avm_waitrequest),
    .avm_readdata    (avm_readdata),
    .id_value        (id_value),
    .ts_value        (ts_value),
    .busy            (busy),
    .done            (done),
    .id_ok           (id_ok),
    .id_mismatch     (id_mismatch),
    .ts_mismatch     (ts_mismatch),
    .timeout         (timeout)
  );

  // Slave model: stalls each read for stall_len cycles, then returns the word for the address.
  assign avm_waitrequest = avm_read && (stall_ctr < stall_len);
  assign avm_readdata    = avm_address ? ts_resp : id_resp;

  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) stall_ctr <= 0;
    else if (!avm_read || !avm_waitrequest) stall_ctr <= 0;
    else stall_ctr <= stall_ctr + 1;
  end

  // Protocol monitor: read/address must not move while stalled; note any timestamp read.
  always @(negedge clock) begin
    if (!reset_n) begin
      prev_hold <= 1'b0;
    end else begin
      if (prev_hold && !(avm_read && avm_address == prev_addr)) hold_viol <= hold_viol + 1;
      if (avm_read && avm_address) ts_issued <= ts_issued + 1;
      prev_hold <= avm_read && avm_waitrequest;
      prev_addr <= avm_address;
    end
  end

  task automatic do_reset();
    reset_n = 1'b0;
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset_n = 1'b1;
  endtask

  // Counts rising edges until done is seen at a falling edge (bounded).
  task automatic run_until_done(output int n);
    n = 0;
    do begin
      @(posedge clock);
      @(negedge clock);
      n++;
    end while (!done && n < 300);
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    #23;
    total_cnt++;
    if ({avm_read, busy, done, id_ok, id_mismatch, ts_mismatch, timeout} !== 7'b0) begin
      $display("FAIL reset_flags: got %b want 0000000",
               {avm_read, busy, done, id_ok, id_mismatch, ts_mismatch, timeout});
    end else pass_cnt++;
    total_cnt++;
    if ({id_value, ts_value} !== 64'h0) begin
      $display("FAIL reset_values: got %h %h want 0 0", id_value, ts_value);
    end else pass_cnt++;
  endtask

  task automatic test_match();
    int n;
    stall_len = 0; id_resp = EXP_ID; ts_resp = EXP_TS;
    do_reset();
    @(posedge clock); @(negedge clock);
    total_cnt++;
    if (busy !== 1'b1 || done !== 1'b0) $display("FAIL match_busy_wait: got busy=%b done=%b want 1 0", busy, done);
    else pass_cnt++;
    run_until_done(n);
    n = n + 1;
    total_cnt++;
    if (n !== SD + 2) $display("FAIL match_latency: got %0d cycles want %0d", n, SD + 2);
    else pass_cnt++;
    total_cnt++;
    if ({done, id_ok, busy, avm_read, id_mismatch, ts_mismatch, timeout} !== 7'b1100000)
      $display("FAIL match_flags: got %b want 1100000",
               {done, id_ok, busy, avm_read, id_mismatch, ts_mismatch, timeout});
    else pass_cnt++;
    total_cnt++;
    if (id_value !== EXP_ID || ts_value !== EXP_TS)
      $display("FAIL match_values: got %h %h want %h %h", id_value, ts_value, EXP_ID, EXP_TS);
    else pass_cnt++;
  endtask

  task automatic test_wait_states();
    int n, v0;
    stall_len = 5; id_resp = EXP_ID; ts_resp = EXP_TS;
    do_reset();
    v0 = hold_viol;
    run_until_done(n);
    total_cnt++;
    if (n !== SD + 12) $display("FAIL wait_latency: got %0d cycles want %0d", n, SD + 12);
    else pass_cnt++;
    total_cnt++;
    if (hold_viol !== v0) $display("FAIL wait_hold_stable: got %0d violations want 0", hold_viol - v0);
    else pass_cnt++;
    total_cnt++;
    if (id_ok !== 1'b1 || ts_value !== EXP_TS) $display("FAIL wait_result: got id_ok=%b ts=%h want 1 %h", id_ok, ts_value, EXP_TS);
    else pass_cnt++;
  endtask

  task automatic test_id_mismatch();
    int n;
    stall_len = 0; id_resp = 32'hDEAD_BEEF; ts_resp = EXP_TS;
    do_reset();
    run_until_done(n);
    total_cnt++;
    if ({done, id_mismatch, ts_mismatch, id_ok, timeout} !== 5'b11000)
      $display("FAIL idmis_flags: got %b want 11000", {done, id_mismatch, ts_mismatch, id_ok, timeout});
    else pass_cnt++;
    total_cnt++;
    if (id_value !== 32'hDEAD_BEEF) $display("FAIL idmis_value: got %h want deadbeef", id_value);
    else pass_cnt++;
  endtask

  // Runs from the mismatch result: recheck in DONE restarts, a second pulse mid-RD_TS is ignored.
  task automatic test_recheck();
    int n, guard;
    stall_len = 2; id_resp = EXP_ID; ts_resp = EXP_TS;
    repeat (3) @(negedge clock);
    recheck = 1'b1;
    @(posedge clock); @(negedge clock);
    recheck = 1'b0;
    total_cnt++;
    if ({done, id_mismatch, id_ok, busy, avm_read, avm_address} !== 6'b000110)
      $display("FAIL recheck_restart: got %b want 000110", {done, id_mismatch, id_ok, busy, avm_read, avm_address});
    else pass_cnt++;
    total_cnt++;
    if (id_value !== 32'hDEAD_BEEF) $display("FAIL recheck_keep_value: got %h want deadbeef", id_value);
    else pass_cnt++;
    n = 0; guard = 0;
    while (!(avm_read && avm_address) && guard < 50) begin
      @(posedge clock); @(negedge clock);
      n++; guard++;
    end
    recheck = 1'b1;
    @(posedge clock); @(negedge clock);
    recheck = 1'b0;
    n++;
    total_cnt++;
    if (avm_read !== 1'b1 || avm_address !== 1'b1)
      $display("FAIL recheck_ignored: got read=%b addr=%b want 1 1", avm_read, avm_address);
    else pass_cnt++;
    while (!done && guard < 50) begin
      @(posedge clock); @(negedge clock);
      n++; guard++;
    end
    total_cnt++;
    if (n !== 6) $display("FAIL recheck_latency: got %0d cycles want 6", n);
    else pass_cnt++;
    total_cnt++;
    if (id_ok !== 1'b1 || id_value !== EXP_ID)
      $display("FAIL recheck_result: got id_ok=%b id=%h want 1 %h", id_ok, id_value, EXP_ID);
    else pass_cnt++;
  endtask

  task automatic test_timeout();
    int n, t0;
    stall_len = 1000; id_resp = EXP_ID; ts_resp = EXP_TS;
    do_reset();
    t0 = ts_issued;
    run_until_done(n);
    total_cnt++;
    if (n !== SD + TO) $display("FAIL timeout_latency: got %0d cycles want %0d", n, SD + TO);
    else pass_cnt++;
    repeat (3) @(negedge clock);
    total_cnt++;
    if ({timeout, done, id_ok, avm_read, busy, id_mismatch} !== 6'b110000)
      $display("FAIL timeout_flags: got %b want 110000", {timeout, done, id_ok, avm_read, busy, id_mismatch});
    else pass_cnt++;
    total_cnt++;
    if (ts_issued !== t0 || id_value !== 32'h0)
      $display("FAIL timeout_no_ts: got ts_reads=%0d id=%h want 0 0", ts_issued - t0, id_value);
    else pass_cnt++;
  endtask

  task automatic test_reset_mid_read();
    int n, guard;
    stall_len = 1000;
    do_reset();
    guard = 0;
    while (!avm_read && guard < 50) begin
      @(posedge clock); @(negedge clock);
      guard++;
    end
    @(posedge clock); #2;
    reset_n = 1'b0;
    #1;
    total_cnt++;
    if ({avm_read, busy, done, id_ok, timeout} !== 5'b0)
      $display("FAIL midread_async: got %b want 00000", {avm_read, busy, done, id_ok, timeout});
    else pass_cnt++;
    stall_len = 0;
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset_n = 1'b1;
    run_until_done(n);
    total_cnt++;
    if (n !== SD + 2 || id_ok !== 1'b1)
      $display("FAIL midread_rerun: got %0d cycles id_ok=%b want %0d 1", n, id_ok, SD + 2);
    else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_match();
    test_wait_states();
    test_id_mismatch();
    test_recheck();
    test_timeout();
    test_reset_mid_read();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
